// File: rtl/io_perf_monitor.sv
// Memory-mapped performance monitor: event counters, CPU clock-enable generator
// (run / slow / single-step), switch, LED and hex-display glue. Optional IO_PERF_SNAPSHOT_EN adds shadow counters.
module io_perf_monitor #(
   parameter int NUM_CNT = 4,
   parameter int CNT_W   = 32,
   parameter int DIV_W   = 26,
   parameter int SW_W    = 10
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   input  logic               we,
   input  logic               re,
   output logic [31:0]        rdata,
   input  logic [NUM_CNT-1:0] event_in,
   input  logic               halt,
   input  logic [SW_W-1:0]    sw,
   input  logic               step_btn,
   output logic               cpu_ce,
   output logic [23:0]        hex_val,
   output logic [9:0]         ledr
);

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SLOW     = 2'd1,
      MODE_STEP     = 2'd2,
      MODE_STEP_ALT = 2'd3
   } mode_t;

   localparam logic [5:0]       OFF_CTRL   = 6'd0;
   localparam logic [5:0]       OFF_STATUS = 6'd1;
   localparam logic [5:0]       OFF_SW     = 6'd2;
   localparam logic [5:0]       OFF_LED    = 6'd3;
   localparam logic [5:0]       OFF_CNT    = 6'd8;
   localparam logic [CNT_W-1:0] CNT_ONE    = 1;
   localparam logic [DIV_W-1:0] DIV_ONE    = 1;

   // Bus: we and re are single-cycle strobes, one per access, no back-pressure;
   // read data appears on rdata the cycle after re and is held until the next read.
   logic [5:0] off;
   logic       wr_ctrl;
   logic       clear_req;
   logic       mode_change;

   mode_t      mode;
   logic [3:0] hexsel;

   logic [SW_W-1:0] sw_s1, sw_s2;
   logic            halt_s1, halt_sync;
   logic            step_s1, step_s2, step_s3;
   logic            step_rise;

   logic [DIV_W-1:0] div;
   logic             run_q;
   logic             step_pulse;
   logic             ce_block;
   logic             ce_sel;
   logic             count_en;

   logic [CNT_W-1:0]   cnt [NUM_CNT];
   logic [CNT_W-1:0]   cnt_view [NUM_CNT];
   logic [NUM_CNT-1:0] ovf;
   logic [31:0]        rd_next;
   logic [23:0]        hex_next;
   logic               unused_bits;

   assign off         = addr[7:2];
   assign wr_ctrl     = we && (off == OFF_CTRL);
   assign clear_req   = wr_ctrl && wdata[2];
   assign mode_change = wr_ctrl && (wdata[1:0] != mode);
   assign unused_bits = ^{addr[31:8], addr[1:0], wdata[31:10]};

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         mode   <= MODE_RUN;
         hexsel <= 4'd0;
      end else if (wr_ctrl) begin
         mode   <= mode_t'(wdata[1:0]);
         hexsel <= wdata[7:4];
      end
   end

   // Forcing the step pipeline high on a mode change swallows any edge in flight;
   // a button already held must be released before it can step again.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sw_s1     <= '0;
         sw_s2     <= '0;
         halt_s1   <= 1'b0;
         halt_sync <= 1'b0;
         step_s1   <= 1'b0;
         step_s2   <= 1'b0;
         step_s3   <= 1'b0;
      end else begin
         sw_s1     <= sw;
         sw_s2     <= sw_s1;
         halt_s1   <= halt;
         halt_sync <= halt_s1;
         step_s1   <= step_btn;
         if (mode_change) begin
            step_s2 <= 1'b1;
            step_s3 <= 1'b1;
         end else begin
            step_s2 <= step_s1;
            step_s3 <= step_s2;
         end
      end
   end

   assign step_rise = step_s2 && !step_s3;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         div        <= '0;
         run_q      <= 1'b0;
         step_pulse <= 1'b0;
         ce_block   <= 1'b0;
      end else begin
         run_q    <= 1'b1;
         ce_block <= mode_change;
         if (mode_change) begin
            div        <= '0;
            step_pulse <= 1'b0;
         end else begin
            div        <= div + DIV_ONE;
            step_pulse <= step_rise && (mode == MODE_STEP || mode == MODE_STEP_ALT);
         end
      end
   end

   always_comb begin
      ce_sel = 1'b0;
      case (mode)
         MODE_RUN:  ce_sel = run_q;
         MODE_SLOW: ce_sel = &div;
         default:   ce_sel = step_pulse;
      endcase
      cpu_ce = ce_sel && !ce_block;
   end

   assign count_en = cpu_ce && !halt_sync;

   // Clear takes priority over an increment landing in the same cycle.
   always_ff @(posedge CLOCK_50) begin
      if (reset || clear_req) begin
         for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
         ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (count_en && event_in[i]) begin
               cnt[i] <= cnt[i] + CNT_ONE;
               if (&cnt[i]) ovf[i] <= 1'b1;
            end
         end
      end
   end

`ifdef IO_PERF_SNAPSHOT_EN
   logic [CNT_W-1:0] shadow [NUM_CNT];

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
      end else if (wr_ctrl && wdata[3]) begin
         for (int i = 0; i < NUM_CNT; i++) shadow[i] <= cnt[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) cnt_view[i] = shadow[i];
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) cnt_view[i] = cnt[i];
   end
`endif

   always_comb begin
      rd_next = 32'd0;
      case (off)
         OFF_CTRL:   rd_next[7:0] = {hexsel, 2'b00, mode};
         OFF_STATUS: begin
            rd_next[8 +: NUM_CNT] = ovf;
            rd_next[0]            = halt_sync;
         end
         OFF_SW:     rd_next[SW_W-1:0] = sw_s2;
         OFF_LED:    rd_next[9:0] = ledr;
         default: begin
            for (int i = 0; i < NUM_CNT; i++) begin
               if (off == OFF_CNT + 6'(i)) rd_next[CNT_W-1:0] = cnt_view[i];
            end
         end
      endcase
   end

   always_comb begin
      hex_next = 24'd0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (hexsel == 4'(i)) hex_next = 24'(32'(cnt[i]));
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rdata   <= 32'd0;
         ledr    <= 10'd0;
         hex_val <= 24'd0;
      end else begin
         if (re) rdata <= rd_next;
         if (we && off == OFF_LED) ledr <= wdata[9:0];
         hex_val <= hex_next;
      end
   end

endmodule

// File: tb/tb_io_perf_monitor.sv
// Directed bench for io_perf_monitor (CNT_W=8, DIV_W=4) with hand-computed expectations.
module tb_io_perf_monitor;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic [31:0] rdata;
   logic [3:0]  event_in;
   logic        halt;
   logic [9:0]  sw;
   logic        step_btn;
   logic        cpu_ce;
   logic [23:0] hex_val;
   logic [9:0]  ledr;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] ctrl_q  = 32'd0;
   logic [31:0] rd;

   io_perf_monitor #(.NUM_CNT(4), .CNT_W(8), .DIV_W(4), .SW_W(10)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .addr     (addr),
      .wdata    (wdata),
      .we       (we),
      .re       (re),
      .rdata    (rdata),
      .event_in (event_in),
      .halt     (halt),
      .sw       (sw),
      .step_btn (step_btn),
      .cpu_ce   (cpu_ce),
      .hex_val  (hex_val),
      .ledr     (ledr)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // All bus tasks are entered just after a falling edge and return on one.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(negedge CLOCK_50);
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      re   = 1'b1;
      @(negedge CLOCK_50);
      re = 1'b0;
      d  = rdata;
   endtask

   task automatic set_ctrl(input logic [31:0] v);
      ctrl_q = v & 32'h0000_00F3;
      bus_write(32'h00, v);
   endtask

   task automatic read_cnt(input int i, output logic [31:0] d);
`ifdef IO_PERF_SNAPSHOT_EN
      bus_write(32'h00, ctrl_q | 32'h8);
`endif
      bus_read(32'h20 + 32'(4 * i), d);
   endtask

   task automatic step_press(input string tag, inout int total);
      int first;
      first    = -1;
      step_btn = 1'b1;
      for (int j = 1; j <= 50; j++) begin
         @(negedge CLOCK_50);
         if (cpu_ce) begin
            total++;
            if (first < 0) first = j;
         end
      end
      check(tag, 32'(first), 32'd3);
      step_btn = 1'b0;
      for (int j = 1; j <= 50; j++) begin
         @(negedge CLOCK_50);
         if (cpu_ce) total++;
      end
   endtask

   initial begin
      int ce_hi;
      int pulses;
      int first_p;
      int last_p;
      int step_total;

      reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
      event_in = '0; halt = 1'b0; sw = '0; step_btn = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check("reset_rdata", rdata, 32'd0);
      check("reset_ledr", 32'(ledr), 32'd0);
      check("reset_hex", 32'(hex_val), 32'd0);
      check("reset_cpu_ce", 32'(cpu_ce), 32'd0);
      reset = 1'b0;
      @(negedge CLOCK_50);
      check("run_ce_after_reset", 32'(cpu_ce), 32'd1);

      // Run mode: 100 events on counter 0
      event_in = 4'b0001;
      ce_hi = 0;
      for (int k = 0; k < 100; k++) begin
         if (cpu_ce) ce_hi++;
         @(negedge CLOCK_50);
      end
      event_in = 4'b0000;
      check("run_ce_cycles", 32'(ce_hi), 32'd100);
      @(negedge CLOCK_50);
      check("hex_cnt0", 32'(hex_val), 32'd100);
      for (int i = 0; i < 4; i++) begin
         read_cnt(i, rd);
         check($sformatf("run_cnt%0d", i), rd, (i == 0) ? 32'd100 : 32'd0);
      end

      // Overflow on counter 1 after 257 increments, then clear
      set_ctrl(32'h4);
      event_in = 4'b0010;
      repeat (257) @(negedge CLOCK_50);
      event_in = 4'b0000;
      bus_read(32'h04, rd);
      check("ovf_status", rd, 32'h0000_0200);
      read_cnt(1, rd);
      check("ovf_cnt1_wrap", rd, 32'd1);
      read_cnt(0, rd);
      check("clear_cnt0", rd, 32'd0);
      set_ctrl(32'h4);
      read_cnt(1, rd);
      check("clear_cnt1", rd, 32'd0);
      bus_read(32'h04, rd);
      check("clear_status", rd, 32'd0);

      // hex selection
      set_ctrl(32'h10);
      event_in = 4'b0010;
      repeat (5) @(negedge CLOCK_50);
      event_in = 4'b0000;
      @(negedge CLOCK_50);
      check("hex_cnt1", 32'(hex_val), 32'd5);
      set_ctrl(32'h50);
      @(negedge CLOCK_50);
      check("hex_out_of_range", 32'(hex_val), 32'd0);

      // Switches, LEDs, unmapped reads, CTRL readback
      sw = 10'h2A5;
      repeat (3) @(negedge CLOCK_50);
      bus_read(32'h08, rd);
      check("sw_read", rd, 32'h0000_02A5);
      repeat (2) @(negedge CLOCK_50);
      check("rdata_hold", rdata, 32'h0000_02A5);
      bus_write(32'h08, 32'h0000_0000);
      bus_read(32'h08, rd);
      check("sw_write_ignored", rd, 32'h0000_02A5);
      bus_write(32'h0C, 32'h0000_03FF);
      check("ledr_3ff", 32'(ledr), 32'h3FF);
      bus_write(32'h0C, 32'hFFFF_FD55);
      check("ledr_low10", 32'(ledr), 32'h155);
      bus_read(32'h40, rd);
      check("unmapped_0x40", rd, 32'd0);
      bus_read(32'h30, rd);
      check("cnt_index_oob", rd, 32'd0);
      set_ctrl(32'h5C);
      bus_read(32'h00, rd);
      check("ctrl_selfclear", rd, 32'h0000_0050);

      // Slow mode: pulse every 16 cycles, divider restarts at the mode write
      set_ctrl(32'h1);
      pulses = 0; first_p = -1; last_p = -1;
      for (int j = 0; j < 48; j++) begin
         if (cpu_ce) begin
            pulses++;
            if (first_p < 0) first_p = j;
            last_p = j;
         end
         @(negedge CLOCK_50);
      end
      check("slow_first", 32'(first_p), 32'd15);
      check("slow_pulses", 32'(pulses), 32'd3);
      check("slow_period", 32'(last_p - first_p), 32'd32);

      // Halt freezes counting two cycles after it rises
      set_ctrl(32'h0);
      set_ctrl(32'h4);
      event_in = 4'b0001;
      repeat (10) @(negedge CLOCK_50);
      halt = 1'b1;
      repeat (10) @(negedge CLOCK_50);
      event_in = 4'b0000;
      bus_read(32'h04, rd);
      check("halt_status", rd, 32'h0000_0001);
      read_cnt(0, rd);
      check("halt_freeze", rd, 32'd12);
      halt = 1'b0;
      repeat (3) @(negedge CLOCK_50);

      // Single-step mode: two presses, two pulses
      set_ctrl(32'h6);
      event_in = 4'b0001;
      step_total = 0;
      step_press("step1_latency", step_total);
      step_press("step2_latency", step_total);
      event_in = 4'b0000;
      check("step_pulses", 32'(step_total), 32'd2);
      read_cnt(0, rd);
      check("step_cnt0", rd, 32'd2);

      // Snapshot at 50, twenty more counts
      set_ctrl(32'h0);
      set_ctrl(32'h4);
      event_in = 4'b0001;
      repeat (50) @(negedge CLOCK_50);
      bus_write(32'h00, 32'h8);
      repeat (19) @(negedge CLOCK_50);
      event_in = 4'b0000;
      bus_read(32'h20, rd);
`ifdef IO_PERF_SNAPSHOT_EN
      check("snapshot_cnt0", rd, 32'd50);
`else
      check("snapshot_cnt0", rd, 32'd70);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
